// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master / three-slave arbiter and serial-bus router.
// Grants the bus to one requesting master, captures the 2-bit slave-select
// prefix, waits for the selected slave to be ready, then routes the serial
// lines in both directions (one register stage each way) until the master
// drops its request.
// Optional feature: define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests; without it master 0 has fixed priority.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       rstn,
  input  logic [1:0] bus_req,
  input  logic [1:0] valid_s_m,
  input  logic [1:0] addr_tx_m,
  input  logic [1:0] data_tx_m,
  input  logic [1:0] write_en_m,
  input  logic [2:0] slave_ready,
  input  logic [2:0] slave_valid,
  input  logic [2:0] data_rx_s,
  output logic [1:0] bus_ready_m,
  output logic [2:0] slave_sel,
  output logic       addr_tx_s,
  output logic       data_tx_s,
  output logic       valid_s_s,
  output logic       write_en_s,
  output logic [1:0] data_rx_m,
  output logic [1:0] slave_valid_m,
  output logic       grant_id,
  output logic       decode_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    SEL    = 3'd2,
    CHECK  = 3'd3,
    ACTIVE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);

  state_t     state;
  logic [1:0] sel_sr;
  logic       bit_cnt;
  logic [9:0] act_cnt;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic       rr_pref;
`endif

  logic [3:0] ready4;
  logic [3:0] vld4;
  logic [3:0] rx4;
  logic       winner;
  logic       g_req;
  logic       g_valid;
  logic       g_addr;
  logic       g_data;
  logic       g_we;
  logic       sel_ready;
  logic       sel_vld;
  logic       sel_rx;
  logic [9:0] act_cnt_nxt;

  // One-hot slave select for a valid 2-bit select code (11 never reaches here)
  function automatic logic [2:0] decode_sel(input logic [1:0] s);
    case (s)
      2'b00:   decode_sel = 3'b001;
      2'b01:   decode_sel = 3'b010;
      2'b10:   decode_sel = 3'b100;
      default: decode_sel = 3'b000;
    endcase
  endfunction

  // Granted-master and selected-slave line muxes plus arbitration winner
  always_comb begin
    ready4      = {1'b0, slave_ready};
    vld4        = {1'b0, slave_valid};
    rx4         = {1'b0, data_rx_s};
    g_req       = bus_req[grant_id];
    g_valid     = valid_s_m[grant_id];
    g_addr      = addr_tx_m[grant_id];
    g_data      = data_tx_m[grant_id];
    g_we        = write_en_m[grant_id];
    sel_ready   = ready4[sel_sr];
    sel_vld     = vld4[sel_sr];
    sel_rx      = rx4[sel_sr];
    act_cnt_nxt = act_cnt + 10'd1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    // On a tie the preferred master is the one not granted last time
    if (bus_req == 2'b11) winner = rr_pref;
    else                  winner = bus_req[1];
`else
    // Master 1 only wins when master 0 is not requesting
    winner = ~bus_req[0];
`endif
  end

  // Arbitration / routing FSM; every output is a register of this block
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      sel_sr        <= 2'b00;
      bit_cnt       <= 1'b0;
      act_cnt       <= 10'd0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      rr_pref       <= 1'b0;
`endif
      bus_ready_m   <= 2'b00;
      slave_sel     <= 3'b000;
      addr_tx_s     <= 1'b0;
      data_tx_s     <= 1'b0;
      valid_s_s     <= 1'b0;
      write_en_s    <= 1'b0;
      data_rx_m     <= 2'b00;
      slave_valid_m <= 2'b00;
      grant_id      <= 1'b0;
      decode_err    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // Routed lines are zero unless a cycle of ACTIVE routing overrides them
      addr_tx_s     <= 1'b0;
      data_tx_s     <= 1'b0;
      valid_s_s     <= 1'b0;
      write_en_s    <= 1'b0;
      data_rx_m     <= 2'b00;
      slave_valid_m <= 2'b00;
      case (state)
        IDLE: begin
          bus_ready_m <= 2'b00;
          slave_sel   <= 3'b000;
          if (|bus_req) begin
            grant_id    <= winner;
            bus_ready_m <= winner ? 2'b10 : 2'b01;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_pref     <= ~winner;
`endif
            state       <= GRANT;
          end
        end
        GRANT: begin
          bus_ready_m <= 2'b00;
          sel_sr      <= 2'b00;
          bit_cnt     <= 1'b0;
          state       <= SEL;
        end
        SEL: begin
          if (!g_req) begin
            state <= IDLE;
          end else if (g_valid) begin
            sel_sr  <= {sel_sr[0], g_addr};
            bit_cnt <= 1'b1;
            if (bit_cnt) state <= CHECK;
          end
        end
        CHECK: begin
          if (sel_sr == 2'b11) begin
            decode_err <= 1'b1;
            state      <= HOLD;
          end else if (sel_ready) begin
            bus_ready_m <= grant_id ? 2'b10 : 2'b01;
            slave_sel   <= decode_sel(sel_sr);
            act_cnt     <= 10'd0;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!g_req) begin
            bus_ready_m <= 2'b00;
            slave_sel   <= 3'b000;
            state       <= IDLE;
          end else if (!sel_ready) begin
            // Slave backed off: re-wait for ready, master restarts its frame
            bus_ready_m <= 2'b00;
            slave_sel   <= 3'b000;
            act_cnt     <= 10'd0;
            state       <= CHECK;
          end else if (act_cnt_nxt == TIMEOUT_LIM) begin
            timeout_err <= 1'b1;
            bus_ready_m <= 2'b00;
            slave_sel   <= 3'b000;
            state       <= HOLD;
          end else begin
            act_cnt       <= act_cnt_nxt;
            addr_tx_s     <= g_addr;
            data_tx_s     <= g_data;
            valid_s_s     <= g_valid;
            write_en_s    <= g_we;
            data_rx_m     <= grant_id ? {sel_rx, 1'b0} : {1'b0, sel_rx};
            slave_valid_m <= grant_id ? {sel_vld, 1'b0} : {1'b0, sel_vld};
          end
        end
        HOLD: begin
          bus_ready_m <= 2'b00;
          slave_sel   <= 3'b000;
          if (!g_req) state <= IDLE;
        end
        default: begin
          bus_ready_m <= 2'b00;
          slave_sel   <= 3'b000;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: scenario tasks with randomized payloads and
// noise, expectations derived from the bus protocol timing rules.
module tb_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rstn;
  logic [1:0] bus_req, valid_s_m, addr_tx_m, data_tx_m, write_en_m;
  logic [2:0] slave_ready, slave_valid, data_rx_s;

  logic [1:0] bus_ready_m, data_rx_m, slave_valid_m;
  logic [2:0] slave_sel;
  logic       addr_tx_s, data_tx_s, valid_s_s, write_en_s, grant_id, decode_err, timeout_err;

  logic [1:0] t_bus_ready_m, t_data_rx_m, t_slave_valid_m;
  logic [2:0] t_slave_sel;
  logic       t_addr_tx_s, t_data_tx_s, t_valid_s_s, t_write_en_s, t_grant_id, t_decode_err, t_timeout_err;

  int checks   = 0;
  int failures = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  int rr_pref_m = 0;
`endif

  bus_arbiter dut (
    .clock(clock), .rstn(rstn), .bus_req(bus_req), .valid_s_m(valid_s_m),
    .addr_tx_m(addr_tx_m), .data_tx_m(data_tx_m), .write_en_m(write_en_m),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx_s(data_rx_s),
    .bus_ready_m(bus_ready_m), .slave_sel(slave_sel), .addr_tx_s(addr_tx_s),
    .data_tx_s(data_tx_s), .valid_s_s(valid_s_s), .write_en_s(write_en_s),
    .data_rx_m(data_rx_m), .slave_valid_m(slave_valid_m), .grant_id(grant_id),
    .decode_err(decode_err), .timeout_err(timeout_err)
  );

  bus_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
    .clock(clock), .rstn(rstn), .bus_req(bus_req), .valid_s_m(valid_s_m),
    .addr_tx_m(addr_tx_m), .data_tx_m(data_tx_m), .write_en_m(write_en_m),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx_s(data_rx_s),
    .bus_ready_m(t_bus_ready_m), .slave_sel(t_slave_sel), .addr_tx_s(t_addr_tx_s),
    .data_tx_s(t_data_tx_s), .valid_s_s(t_valid_s_s), .write_en_s(t_write_en_s),
    .data_rx_m(t_data_rx_m), .slave_valid_m(t_slave_valid_m), .grant_id(t_grant_id),
    .decode_err(t_decode_err), .timeout_err(t_timeout_err)
  );

  function automatic logic [15:0] outs_now();
    return {bus_ready_m, slave_sel, addr_tx_s, data_tx_s, valid_s_s, write_en_s,
            data_rx_m, slave_valid_m, grant_id, decode_err, timeout_err};
  endfunction

  function automatic logic [15:0] t_outs_now();
    return {t_bus_ready_m, t_slave_sel, t_addr_tx_s, t_data_tx_s, t_valid_s_s, t_write_en_s,
            t_data_rx_m, t_slave_valid_m, t_grant_id, t_decode_err, t_timeout_err};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus_req = 2'b00; valid_s_m = 2'b00; addr_tx_m = 2'b00; data_tx_m = 2'b00;
    write_en_m = 2'b00; slave_ready = 3'b000; slave_valid = 3'b000; data_rx_s = 3'b000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    rr_pref_m = 0;
`endif
    tick();
  endtask

  // Reference arbitration: who wins when the idle bus sees request vector req
  task automatic model_grant(input logic [1:0] req, output int w);
`ifdef BUS_ARB_ROUND_ROBIN_EN
    if (req == 2'b11) w = rr_pref_m;
    else              w = req[1] ? 1 : 0;
    rr_pref_m = 1 - w;
`else
    w = req[0] ? 0 : 1;
`endif
  endtask

  // Master m requests, then shifts out its 2-bit select; ends in CHECK
  task automatic acquire(input int m, input logic [1:0] sel,
                         output logic [1:0] gnt_obs, output logic gid_obs);
    bus_req[m] = 1'b1;
    tick();
    gnt_obs = bus_ready_m;
    gid_obs = grant_id;
    tick();
    valid_s_m[m] = 1'b1;
    addr_tx_m[m] = sel[1];
    tick();
    addr_tx_m[m] = sel[0];
    tick();
    valid_s_m[m] = 1'b0;
    addr_tx_m[m] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus_req = 2'b11;
    slave_ready = 3'b111;
    rstn = 1'b0;
    tick();
    checks++;
    if (outs_now() !== 16'h0 || t_outs_now() !== 16'h0)
      $display("FAIL reset_outputs got=%h/%h exp=0", outs_now(), t_outs_now());
    if (outs_now() !== 16'h0 || t_outs_now() !== 16'h0) failures++;
    bus_req = 2'b00;
    rstn = 1'b1;
    tick();
    tick();
    checks++;
    if (outs_now() !== 16'h0) begin
      $display("FAIL idle_after_reset got=%h exp=0", outs_now());
      failures++;
    end
  endtask

  task automatic test_single_write();
    logic [1:0] g;
    logic       gid;
    logic [3:0] exp_fwd;
    logic [3:0] cur;
    do_reset();
    slave_ready = 3'b010;
    acquire(0, 2'b01, g, gid);
    checks++;
    if (g !== 2'b01 || gid !== 1'b0) begin
      $display("FAIL write_grant_pulse got=%b/%b exp=01/0", g, gid);
      failures++;
    end
    checks++;
    if (bus_ready_m !== 2'b00) begin
      $display("FAIL write_check_ready got=%b exp=00", bus_ready_m);
      failures++;
    end
    tick();
    checks++;
    if (bus_ready_m !== 2'b01 || slave_sel !== 3'b010) begin
      $display("FAIL write_active_entry got=%b/%b exp=01/010", bus_ready_m, slave_sel);
      failures++;
    end
    exp_fwd = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      valid_s_m[0]  = 1'b1;
      addr_tx_m[0]  = (i < 12) ? 1'($urandom) : 1'b0;
      data_tx_m[0]  = (i >= 12) ? 1'($urandom) : 1'b0;
      write_en_m[0] = 1'b1;
      valid_s_m[1]  = 1'($urandom);
      addr_tx_m[1]  = 1'($urandom);
      data_tx_m[1]  = 1'($urandom);
      write_en_m[1] = 1'($urandom);
      #1;
      cur = {addr_tx_s, data_tx_s, valid_s_s, write_en_s};
      checks++;
      if (cur !== exp_fwd || bus_ready_m !== 2'b01) begin
        $display("FAIL write_forward[%0d] got=%b rdy=%b exp=%b rdy=01", i, cur, bus_ready_m, exp_fwd);
        failures++;
      end
      exp_fwd = {addr_tx_m[0], data_tx_m[0], valid_s_m[0], write_en_m[0]};
      tick();
    end
    clear_inputs();
    slave_ready = 3'b010;
    #1;
    cur = {addr_tx_s, data_tx_s, valid_s_s, write_en_s};
    checks++;
    if (cur !== exp_fwd) begin
      $display("FAIL write_forward_last got=%b exp=%b", cur, exp_fwd);
      failures++;
    end
    tick();
    checks++;
    if (outs_now() !== 16'h0) begin
      $display("FAIL write_release got=%h exp=0", outs_now());
      failures++;
    end
  endtask

  task automatic test_tie();
    int         w;
    logic [1:0] expg;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      bus_req = 2'b11;
      tick();
      model_grant(2'b11, w);
      expg = 2'b01 << w;
      checks++;
      if (bus_ready_m !== expg || grant_id !== w[0]) begin
        $display("FAIL tie_grant[%0d] got=%b/%b exp=%b/%0d", r, bus_ready_m, grant_id, expg, w);
        failures++;
      end
      tick();
      checks++;
      if (bus_ready_m !== 2'b00) begin
        $display("FAIL tie_pulse_width[%0d] got=%b exp=00", r, bus_ready_m);
        failures++;
      end
      bus_req = 2'b00;
      tick();
    end
  endtask

  task automatic test_read_return();
    logic [1:0]  g;
    logic        gid;
    logic [15:0] pat;
    logic [1:0]  exp_rx, exp_sv;
    logic        b;
    int          w;
    do_reset();
    slave_ready = 3'b100;
    acquire(1, 2'b10, g, gid);
    checks++;
    if (g !== 2'b10 || gid !== 1'b1) begin
      $display("FAIL read_grant got=%b/%b exp=10/1", g, gid);
      failures++;
    end
    tick();
    checks++;
    if (bus_ready_m !== 2'b10 || slave_sel !== 3'b100) begin
      $display("FAIL read_active_entry got=%b/%b exp=10/100", bus_ready_m, slave_sel);
      failures++;
    end
    bus_req[0] = 1'b1;
    write_en_m[1] = 1'b0;
    pat = {8'hA5, 8'($urandom)};
    exp_rx = 2'b00;
    exp_sv = 2'b00;
    for (int i = 0; i < 16; i++) begin
      b = pat[15-i];
      data_rx_s   = {b, 2'($urandom)};
      slave_valid = {1'b1, 2'($urandom)};
      #1;
      checks++;
      if (data_rx_m !== exp_rx || slave_valid_m !== exp_sv || bus_ready_m !== 2'b10 || grant_id !== 1'b1) begin
        $display("FAIL read_return[%0d] got=rx%b v%b r%b g%b exp=rx%b v%b r10 g1",
                 i, data_rx_m, slave_valid_m, bus_ready_m, grant_id, exp_rx, exp_sv);
        failures++;
      end
      exp_rx = {b, 1'b0};
      exp_sv = 2'b10;
      tick();
    end
    data_rx_s = 3'b000;
    slave_valid = 3'b000;
    bus_req = 2'b01;
    #1;
    checks++;
    if (data_rx_m !== exp_rx || slave_valid_m !== exp_sv) begin
      $display("FAIL read_return_last got=%b/%b exp=%b/%b", data_rx_m, slave_valid_m, exp_rx, exp_sv);
      failures++;
    end
    tick();
    checks++;
    if (bus_ready_m !== 2'b00 || data_rx_m !== 2'b00 || slave_sel !== 3'b000) begin
      $display("FAIL read_release got=%b/%b/%b exp=00/00/000", bus_ready_m, data_rx_m, slave_sel);
      failures++;
    end
    tick();
    model_grant(2'b01, w);
    checks++;
    if (bus_ready_m !== 2'b01 || grant_id !== w[0]) begin
      $display("FAIL held_request_grant got=%b/%b exp=01/%0d", bus_ready_m, grant_id, w);
      failures++;
    end
  endtask

  task automatic test_slave_busy();
    logic [1:0] g;
    logic       gid;
    do_reset();
    slave_ready = 3'b000;
    acquire(0, 2'b00, g, gid);
    for (int i = 0; i < 20; i++) begin
      slave_ready = {2'($urandom), 1'b0};
      tick();
      checks++;
      if (bus_ready_m !== 2'b00 || slave_sel !== 3'b000) begin
        $display("FAIL busy_wait[%0d] got=%b/%b exp=00/000", i, bus_ready_m, slave_sel);
        failures++;
      end
    end
    slave_ready = 3'b001;
    tick();
    checks++;
    if (bus_ready_m !== 2'b01 || slave_sel !== 3'b001) begin
      $display("FAIL busy_active_entry got=%b/%b exp=01/001", bus_ready_m, slave_sel);
      failures++;
    end
    for (int k = 2; k <= 10; k++) tick();
    checks++;
    if (t_bus_ready_m !== 2'b01 || t_timeout_err !== 1'b0) begin
      $display("FAIL busy_active_hold got=%b/%b exp=01/0", t_bus_ready_m, t_timeout_err);
      failures++;
    end
    slave_ready = 3'b000;
    tick();
    checks++;
    if (bus_ready_m !== 2'b00 || slave_sel !== 3'b000 || t_bus_ready_m !== 2'b00) begin
      $display("FAIL ready_drop got=%b/%b exp=00/000", bus_ready_m, slave_sel);
      failures++;
    end
    tick();
    slave_ready = 3'b001;
    tick();
    checks++;
    if (bus_ready_m !== 2'b01 || slave_sel !== 3'b001) begin
      $display("FAIL reenter_from_check got=%b/%b exp=01/001", bus_ready_m, slave_sel);
      failures++;
    end
    for (int k = 2; k <= 16; k++) begin
      tick();
      checks++;
      if (t_bus_ready_m !== 2'b01 || t_timeout_err !== 1'b0) begin
        $display("FAIL counter_cleared[%0d] got=%b/%b exp=01/0", k, t_bus_ready_m, t_timeout_err);
        failures++;
      end
    end
    tick();
    checks++;
    if (t_timeout_err !== 1'b1 || t_bus_ready_m !== 2'b00) begin
      $display("FAIL busy_timeout got=%b/%b exp=1/00", t_timeout_err, t_bus_ready_m);
      failures++;
    end
    bus_req = 2'b00;
    tick();
  endtask

  task automatic test_decode_err();
    logic [1:0] g;
    logic       gid;
    logic [1:0] expg;
    int         m;
    int         n;
    m = int'($urandom_range(0, 1));
    expg = 2'b01 << m;
    do_reset();
    slave_ready = 3'b111;
    acquire(m, 2'b11, g, gid);
    checks++;
    if (g !== expg) begin
      $display("FAIL decode_grant got=%b exp=%b", g, expg);
      failures++;
    end
    tick();
    checks++;
    if (decode_err !== 1'b1 || bus_ready_m !== 2'b00 || slave_sel !== 3'b000) begin
      $display("FAIL decode_err_set got=%b/%b/%b exp=1/00/000", decode_err, bus_ready_m, slave_sel);
      failures++;
    end
    n = int'($urandom_range(2, 6));
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (bus_ready_m !== 2'b00 || decode_err !== 1'b1) begin
        $display("FAIL decode_hold[%0d] got=%b/%b exp=00/1", i, bus_ready_m, decode_err);
        failures++;
      end
    end
    bus_req = 2'b00;
    tick();
    bus_req[m] = 1'b1;
    tick();
    checks++;
    if (bus_ready_m !== expg || decode_err !== 1'b1 || timeout_err !== 1'b0) begin
      $display("FAIL decode_regrant got=%b/%b/%b exp=%b/1/0", bus_ready_m, decode_err, timeout_err, expg);
      failures++;
    end
    bus_req = 2'b00;
    tick();
  endtask

  task automatic test_timeout_and_reset();
    logic [1:0] g;
    logic       gid;
    do_reset();
    slave_ready = 3'b010;
    acquire(0, 2'b01, g, gid);
    tick();
    checks++;
    if (t_bus_ready_m !== 2'b01 || t_slave_sel !== 3'b010) begin
      $display("FAIL timeout_entry got=%b/%b exp=01/010", t_bus_ready_m, t_slave_sel);
      failures++;
    end
    for (int k = 2; k <= 16; k++) begin
      tick();
      checks++;
      if (t_bus_ready_m !== 2'b01 || t_timeout_err !== 1'b0) begin
        $display("FAIL timeout_early[%0d] got=%b/%b exp=01/0", k, t_bus_ready_m, t_timeout_err);
        failures++;
      end
    end
    tick();
    checks++;
    if (t_timeout_err !== 1'b1 || t_bus_ready_m !== 2'b00 || t_slave_sel !== 3'b000) begin
      $display("FAIL timeout_fire got=%b/%b/%b exp=1/00/000", t_timeout_err, t_bus_ready_m, t_slave_sel);
      failures++;
    end
    tick();
    checks++;
    if (t_bus_ready_m !== 2'b00 || timeout_err !== 1'b0 || bus_ready_m !== 2'b01) begin
      $display("FAIL timeout_hold got=%b/%b/%b exp=00/0/01", t_bus_ready_m, timeout_err, bus_ready_m);
      failures++;
    end
    valid_s_m[0] = 1'b1; addr_tx_m[0] = 1'b1; data_tx_m[0] = 1'b1; write_en_m[0] = 1'b1;
    tick();
    checks++;
    if ({addr_tx_s, data_tx_s, valid_s_s, write_en_s} !== 4'b1111) begin
      $display("FAIL pre_reset_forward got=%b exp=1111", {addr_tx_s, data_tx_s, valid_s_s, write_en_s});
      failures++;
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (outs_now() !== 16'h0 || t_outs_now() !== 16'h0) begin
      $display("FAIL async_reset got=%h/%h exp=0", outs_now(), t_outs_now());
      failures++;
    end
    clear_inputs();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_tie();
    test_read_return();
    test_slave_busy();
    test_decode_err();
    test_timeout_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
